scarv_cop_mp_seq: RTL and testbench

Multi-limb sequencer for the coprocessor multi-precision ALU. It takes one command (op, limb count, three base addresses) and walks the operands least-significant limb first. For each limb it fetches the A and B words from a limb memory and issues one single-limb add3/sub3/equ/ltu instruction to the ALU. It chains carry, borrow or compare state between limbs, writes result limbs back, and reports a final flag.

---
 rtl/scarv_cop_mp_seq_pkg.sv | 49 ++++
 rtl/scarv_cop_mp_seq.sv | 207 ++++++++++++++++++++
 tb/tb_scarv_cop_mp_seq.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scarv_cop_mp_seq_pkg.sv
// Shared definitions for the multi-precision sequencer: command op and FSM
// state encodings, the ALU subclass codes it issues, and small op helpers.
package scarv_cop_mp_seq_pkg;

    // Command op encoding as presented on cmd_op.
    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_EQU = 2'd2,
        OP_LTU = 2'd3
    } mp_op_t;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RDA  = 3'd1,
        ST_RDB  = 3'd2,
        ST_LDB  = 3'd3,
        ST_EXEC = 3'd4,
        ST_WB   = 3'd5,
        ST_FIN  = 3'd6
    } mp_state_t;

    // Multi-precision ALU subclasses (common coprocessor encoding).
    localparam logic [3:0] SCLASS_EQU_MP  = 4'b0001;
    localparam logic [3:0] SCLASS_LTU_MP  = 4'b0010;
    localparam logic [3:0] SCLASS_ADD3_MP = 4'b0100;
    localparam logic [3:0] SCLASS_SUB3_MP = 4'b0110;

    // Add/sub produce result limbs; compares only produce a flag.
    function automatic logic is_arith(input mp_op_t op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

    // Chain seed: no carry/borrow/less-than yet, equality assumed until disproved.
    function automatic logic chain_init(input mp_op_t op);
        return op == OP_EQU;
    endfunction

    function automatic logic [3:0] op_sclass(input mp_op_t op);
        case (op)
            OP_ADD:  return SCLASS_ADD3_MP;
            OP_SUB:  return SCLASS_SUB3_MP;
            OP_EQU:  return SCLASS_EQU_MP;
            default: return SCLASS_LTU_MP;
        endcase
    endfunction

endpackage

// File: rtl/scarv_cop_mp_seq.sv
// Multi-limb sequencer for the coprocessor multi-precision ALU.
// Walks A and B least-significant limb first, issues one single-limb
// add3/sub3/equ/ltu per limb, chains carry/borrow/compare state, writes
// result limbs back (add/sub) and reports a final flag with a done pulse.
// Ports:
//   g_clk, g_resetn       clock, async active-low reset
//   cmd_*                 command handshake and fields (op, limb count, bases)
//   done, res_flag        completion pulse and final carry/borrow/compare flag
//   lmb_*                 limb memory read (1-cycle latency) and write ports
//   malu_*                single-limb ALU instruction and writeback
module scarv_cop_mp_seq
    import scarv_cop_mp_seq_pkg::*;
#(
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned NLIMB_W = 5
) (
    input  logic               g_clk,
    input  logic               g_resetn,

    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [NLIMB_W-1:0] cmd_nlimbs,
    input  logic [ADDR_W-1:0]  cmd_a_base,
    input  logic [ADDR_W-1:0]  cmd_b_base,
    input  logic [ADDR_W-1:0]  cmd_d_base,

    output logic               done,
    output logic               res_flag,

    output logic               lmb_re,
    output logic [ADDR_W-1:0]  lmb_raddr,
    input  logic [31:0]        lmb_rdata,
    output logic               lmb_we,
    output logic [ADDR_W-1:0]  lmb_waddr,
    output logic [31:0]        lmb_wdata,

    output logic               malu_ivalid,
    output logic [3:0]         malu_subclass,
    output logic [31:0]        malu_rs1,
    output logic [31:0]        malu_rs2,
    output logic [31:0]        malu_rs3,
    output logic [31:0]        malu_gpr_rs1,
    input  logic               malu_idone,
    input  logic [3:0]         malu_rd_ben,
    input  logic [31:0]        malu_rd_wdata
);

    mp_state_t          state_q;
    mp_op_t             op_q;
    logic [NLIMB_W-1:0] nlimbs_q;
    logic [NLIMB_W-1:0] idx_q;
    logic [ADDR_W-1:0]  a_base_q;
    logic [ADDR_W-1:0]  b_base_q;
    logic [ADDR_W-1:0]  d_base_q;
    logic               chain_q;
    logic [31:0]        a_q;
    logic [31:0]        sum_q;
    logic               sum_seen_q;

    logic [NLIMB_W-1:0] idx_inc_c;
    logic [ADDR_W-1:0]  b_addr_c;
    logic [ADDR_W-1:0]  d_addr_c;
    logic [ADDR_W-1:0]  a_next_c;
    logic               last_limb_c;

    // Per-base address adders; addresses wrap modulo 2^ADDR_W.
    assign idx_inc_c   = idx_q + NLIMB_W'(1);
    assign b_addr_c    = b_base_q + ADDR_W'(idx_q);
    assign d_addr_c    = d_base_q + ADDR_W'(idx_q);
    assign a_next_c    = a_base_q + ADDR_W'(idx_inc_c);
    assign last_limb_c = (idx_q == (nlimbs_q - NLIMB_W'(1)));

    // Sequencer FSM; every output is a register updated on the transition
    // into the state that owns it.
    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_ADD;
            nlimbs_q      <= '0;
            idx_q         <= '0;
            a_base_q      <= '0;
            b_base_q      <= '0;
            d_base_q      <= '0;
            chain_q       <= 1'b0;
            a_q           <= '0;
            sum_q         <= '0;
            sum_seen_q    <= 1'b0;
            cmd_ready     <= 1'b1;
            done          <= 1'b0;
            res_flag      <= 1'b0;
            lmb_re        <= 1'b0;
            lmb_raddr     <= '0;
            lmb_we        <= 1'b0;
            lmb_waddr     <= '0;
            lmb_wdata     <= '0;
            malu_ivalid   <= 1'b0;
            malu_subclass <= '0;
            malu_rs1      <= '0;
            malu_rs2      <= '0;
            malu_rs3      <= '0;
            malu_gpr_rs1  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= mp_op_t'(cmd_op);
                        nlimbs_q  <= cmd_nlimbs;
                        a_base_q  <= cmd_a_base;
                        b_base_q  <= cmd_b_base;
                        d_base_q  <= cmd_d_base;
                        idx_q     <= '0;
                        chain_q   <= chain_init(mp_op_t'(cmd_op));
                        cmd_ready <= 1'b0;
                        if (cmd_nlimbs == '0) begin
                            // Empty operands: the flag is just the chain seed.
                            state_q  <= ST_FIN;
                            done     <= 1'b1;
                            res_flag <= chain_init(mp_op_t'(cmd_op));
                        end else begin
                            state_q   <= ST_RDA;
                            lmb_re    <= 1'b1;
                            lmb_raddr <= cmd_a_base;
                        end
                    end
                end

                ST_RDA: begin
                    state_q   <= ST_RDB;
                    lmb_raddr <= b_addr_c;
                end

                ST_RDB: begin
                    state_q <= ST_LDB;
                    a_q     <= lmb_rdata;
                    lmb_re  <= 1'b0;
                end

                // B lands straight in its operand register; no separate copy.
                ST_LDB: begin
                    state_q       <= ST_EXEC;
                    sum_seen_q    <= 1'b0;
                    malu_ivalid   <= 1'b1;
                    malu_subclass <= op_sclass(op_q);
                    if (is_arith(op_q)) begin
                        malu_rs1     <= a_q;
                        malu_rs2     <= lmb_rdata;
                        malu_rs3     <= {31'b0, chain_q};
                        malu_gpr_rs1 <= '0;
                    end else begin
                        malu_rs1     <= '0;
                        malu_rs2     <= a_q;
                        malu_rs3     <= lmb_rdata;
                        malu_gpr_rs1 <= {31'b0, chain_q};
                    end
                end

                ST_EXEC: begin
                    // Low result word arrives on the first enabled beat before idone.
                    if ((malu_rd_ben != 4'b0) && !malu_idone && !sum_seen_q) begin
                        sum_q      <= malu_rd_wdata;
                        sum_seen_q <= 1'b1;
                    end
                    if (malu_idone) begin
                        state_q     <= ST_WB;
                        malu_ivalid <= 1'b0;
                        if (is_arith(op_q)) begin
                            // High word: 1 for carry, all-ones for borrow, else 0.
                            chain_q   <= |malu_rd_wdata;
                            lmb_we    <= 1'b1;
                            lmb_waddr <= d_addr_c;
                            lmb_wdata <= sum_q;
                        end else begin
                            chain_q <= malu_rd_wdata[0];
                        end
                    end
                end

                ST_WB: begin
                    lmb_we <= 1'b0;
                    if (last_limb_c) begin
                        state_q  <= ST_FIN;
                        done     <= 1'b1;
                        res_flag <= chain_q;
                    end else begin
                        state_q   <= ST_RDA;
                        idx_q     <= idx_inc_c;
                        lmb_re    <= 1'b1;
                        lmb_raddr <= a_next_c;
                    end
                end

                ST_FIN: begin
                    state_q   <= ST_IDLE;
                    done      <= 1'b0;
                    cmd_ready <= 1'b1;
                end

                default: begin
                    state_q   <= ST_IDLE;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scarv_cop_mp_seq.sv
// Scoreboard bench for scarv_cop_mp_seq: a behavioural limb memory and
// single-limb ALU surround the DUT; expected writes and completions are
// queued at issue time and checked by an independent monitor.
module tb_scarv_cop_mp_seq;
    import scarv_cop_mp_seq_pkg::*;

    logic        g_clk = 1'b0;
    logic        g_resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_nlimbs;
    logic [4:0]  cmd_a_base, cmd_b_base, cmd_d_base;
    logic        done, res_flag;
    logic        lmb_re, lmb_we;
    logic [4:0]  lmb_raddr, lmb_waddr;
    logic [31:0] lmb_rdata, lmb_wdata;
    logic        malu_ivalid, malu_idone;
    logic [3:0]  malu_subclass, malu_rd_ben;
    logic [31:0] malu_rs1, malu_rs2, malu_rs3, malu_gpr_rs1, malu_rd_wdata;

    scarv_cop_mp_seq #(.ADDR_W(5), .NLIMB_W(5)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_nlimbs(cmd_nlimbs), .cmd_a_base(cmd_a_base),
        .cmd_b_base(cmd_b_base), .cmd_d_base(cmd_d_base),
        .done(done), .res_flag(res_flag),
        .lmb_re(lmb_re), .lmb_raddr(lmb_raddr), .lmb_rdata(lmb_rdata),
        .lmb_we(lmb_we), .lmb_waddr(lmb_waddr), .lmb_wdata(lmb_wdata),
        .malu_ivalid(malu_ivalid), .malu_subclass(malu_subclass),
        .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
        .malu_gpr_rs1(malu_gpr_rs1), .malu_idone(malu_idone),
        .malu_rd_ben(malu_rd_ben), .malu_rd_wdata(malu_rd_wdata)
    );

    always #5 g_clk = ~g_clk;

    int cyc = 0;
    always @(posedge g_clk) cyc <= cyc + 1;

    // Limb memory with one-cycle read latency and a bench-side load port.
    logic [31:0] mem [32];
    logic        tb_we = 1'b0;
    logic [4:0]  tb_addr = '0;
    logic [31:0] tb_data = '0;
    always @(posedge g_clk) begin
        if (tb_we)       mem[tb_addr]   <= tb_data;
        else if (lmb_we) mem[lmb_waddr] <= lmb_wdata;
        if (lmb_re)      lmb_rdata      <= mem[lmb_raddr];
    end

    // ALU model: add3/sub3 take 3 cycles (low word on beat 1, high word with
    // idone on beat 2); equ/ltu complete in the first cycle.
    logic [1:0]  beat;
    logic [63:0] alu_full;
    always @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn)                      beat <= 2'd0;
        else if (malu_ivalid && !malu_idone) beat <= beat + 2'd1;
        else                                beat <= 2'd0;
    end

    always_comb begin
        malu_idone    = 1'b0;
        malu_rd_ben   = 4'h0;
        malu_rd_wdata = 32'h0;
        alu_full      = 64'h0;
        if (malu_ivalid) begin
            case (malu_subclass)
                SCLASS_ADD3_MP, SCLASS_SUB3_MP: begin
                    if (malu_subclass == SCLASS_ADD3_MP)
                        alu_full = {32'h0, malu_rs1} + {32'h0, malu_rs2} + {32'h0, malu_rs3};
                    else
                        alu_full = {32'h0, malu_rs1} - {32'h0, malu_rs2} - {32'h0, malu_rs3};
                    if (beat == 2'd1) begin
                        malu_rd_ben   = 4'hF;
                        malu_rd_wdata = alu_full[31:0];
                    end else if (beat == 2'd2) begin
                        malu_idone    = 1'b1;
                        malu_rd_ben   = 4'hF;
                        malu_rd_wdata = alu_full[63:32];
                    end
                end
                SCLASS_EQU_MP: begin
                    malu_idone    = 1'b1;
                    malu_rd_ben   = 4'hF;
                    malu_rd_wdata = {31'h0, (malu_rs2 == malu_rs3) & malu_gpr_rs1[0]};
                end
                SCLASS_LTU_MP: begin
                    malu_idone    = 1'b1;
                    malu_rd_ben   = 4'hF;
                    malu_rd_wdata = {31'h0, (malu_rs2 < malu_rs3) |
                                            ((malu_rs2 == malu_rs3) & malu_gpr_rs1[0])};
                end
                default: ;
            endcase
        end
    end

    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic flag; int cyc; } dn_t;
    wr_t exp_wr[$];
    dn_t exp_dn[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, exp);
        end
    endtask

    // Monitor: pops expectations whenever the DUT writes a limb or completes.
    initial begin
        forever begin
            @(negedge g_clk);
            if (g_resetn) begin
                if (lmb_we) begin
                    if (exp_wr.size() == 0) begin
                        check("unexpected_write", {22'h0, lmb_waddr, 5'h0}, 32'hFFFFFFFF);
                    end else begin
                        wr_t e;
                        e = exp_wr.pop_front();
                        check("wr_addr", {27'h0, lmb_waddr}, {27'h0, e.addr});
                        check("wr_data", lmb_wdata, e.data);
                    end
                end
                if (done) begin
                    if (exp_dn.size() == 0) begin
                        check("unexpected_done", {31'h0, done}, 32'h0);
                    end else begin
                        dn_t d;
                        d = exp_dn.pop_front();
                        check("res_flag", {31'h0, res_flag}, {31'h0, d.flag});
                        check("done_cycle", cyc, d.cyc);
                    end
                end
            end
        end
    end

    task automatic mem_set(input logic [4:0] a, input logic [31:0] d);
        @(negedge g_clk);
        tb_we = 1'b1; tb_addr = a; tb_data = d;
        @(negedge g_clk);
        tb_we = 1'b0;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a; e.data = d;
        exp_wr.push_back(e);
    endtask

    // Issue one command; acc returns the cycle count just after the accept edge.
    task automatic issue(input logic [1:0] op, input int n, input logic [4:0] a,
                         input logic [4:0] b, input logic [4:0] d, input logic flag,
                         input bit expect_done, output int acc);
        int   waited = 0;
        dn_t  e;
        @(negedge g_clk);
        while (!cmd_ready && waited < 200) begin
            @(negedge g_clk);
            waited++;
        end
        check("cmd_ready_wait", {31'h0, cmd_ready}, 32'h1);
        cmd_op = op; cmd_nlimbs = 5'(n);
        cmd_a_base = a; cmd_b_base = b; cmd_d_base = d;
        cmd_valid = 1'b1;
        @(posedge g_clk);
        #1;
        cmd_valid = 1'b0;
        acc = cyc;
        if (expect_done) begin
            e.flag = flag;
            e.cyc  = acc + ((op == 2'd0 || op == 2'd1) ? 7 : 5) * n;
            exp_dn.push_back(e);
        end
    endtask

    task automatic drain();
        int w = 0;
        while ((exp_dn.size() != 0) && w < 400) begin
            @(negedge g_clk);
            w++;
        end
        check("drain_timeout", exp_dn.size(), 0);
        @(negedge g_clk);
    endtask

    initial begin
        int c;
        g_resetn = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'd0; cmd_nlimbs = '0;
        cmd_a_base = '0; cmd_b_base = '0; cmd_d_base = '0;
        repeat (3) @(negedge g_clk);
        check("rst_cmd_ready", {31'h0, cmd_ready}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_strobes", {29'h0, lmb_re, lmb_we, malu_ivalid}, 32'h0);
        g_resetn = 1'b1;

        // ADD, 2 limbs with carry between limbs.
        mem_set(5'd0, 32'hFFFFFFFF); mem_set(5'd1, 32'h1);
        mem_set(5'd4, 32'h1);        mem_set(5'd5, 32'h0);
        push_wr(5'd8, 32'h0); push_wr(5'd9, 32'h2);
        issue(2'd0, 2, 5'd0, 5'd4, 5'd8, 1'b0, 1'b1, c);
        drain();

        // SUB, 1 limb with borrow-out.
        mem_set(5'd12, 32'h5); mem_set(5'd13, 32'h7);
        push_wr(5'd14, 32'hFFFFFFFE);
        issue(2'd1, 1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b1, c);
        drain();

        // LTU, equal high limbs decided by the low limb, then high limb less.
        mem_set(5'd16, 32'h9); mem_set(5'd17, 32'h1);
        mem_set(5'd18, 32'h3); mem_set(5'd19, 32'h1);
        issue(2'd3, 2, 5'd16, 5'd18, 5'd20, 1'b0, 1'b1, c);
        drain();
        mem_set(5'd17, 32'h0);
        issue(2'd3, 2, 5'd16, 5'd18, 5'd20, 1'b1, 1'b1, c);
        drain();

        // EQU, 3 equal limbs, then a low-limb MSB difference, then zero limbs.
        mem_set(5'd20, 32'h11); mem_set(5'd21, 32'h22); mem_set(5'd22, 32'h33);
        mem_set(5'd23, 32'h11); mem_set(5'd24, 32'h22); mem_set(5'd25, 32'h33);
        issue(2'd2, 3, 5'd20, 5'd23, 5'd0, 1'b1, 1'b1, c);
        drain();
        mem_set(5'd20, 32'h80000011);
        issue(2'd2, 3, 5'd20, 5'd23, 5'd0, 1'b0, 1'b1, c);
        drain();
        issue(2'd2, 0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1, c);
        drain();

        // Address wrap from 31 to 0, with a stray command pulse mid-operation.
        mem_set(5'd31, 32'hFFFFFFFF); mem_set(5'd0, 32'h20);
        mem_set(5'd26, 32'h2);        mem_set(5'd27, 32'h2);
        push_wr(5'd28, 32'h1); push_wr(5'd29, 32'h23);
        issue(2'd0, 2, 5'd31, 5'd26, 5'd28, 1'b0, 1'b1, c);
        repeat (4) @(negedge g_clk);
        check("busy_not_ready", {31'h0, cmd_ready}, 32'h0);
        cmd_op = 2'd2; cmd_nlimbs = 5'd0; cmd_valid = 1'b1;
        @(negedge g_clk);
        cmd_valid = 1'b0;
        drain();

        // Destination overlapping A: limb read before being overwritten.
        mem_set(5'd2, 32'h7); mem_set(5'd3, 32'h8);
        push_wr(5'd2, 32'hF);
        issue(2'd0, 1, 5'd2, 5'd3, 5'd2, 1'b0, 1'b1, c);
        drain();

        // Reset during EXEC of limb 1: only limb 0 is written, no completion.
        mem_set(5'd0, 32'h20); mem_set(5'd1, 32'h1);
        push_wr(5'd10, 32'h21);
        issue(2'd0, 2, 5'd0, 5'd4, 5'd10, 1'b0, 1'b0, c);
        while (cyc < c + 11) @(negedge g_clk);
        check("exec_ivalid", {31'h0, malu_ivalid}, 32'h1);
        g_resetn = 1'b0;
        #1;
        check("arst_strobes", {29'h0, lmb_re, lmb_we, malu_ivalid}, 32'h0);
        check("arst_done_flag", {30'h0, done, res_flag}, 32'h0);
        repeat (2) @(negedge g_clk);
        g_resetn = 1'b1;
        repeat (20) @(negedge g_clk);
        check("arst_writes_left", exp_wr.size(), 0);

        // Normal operation after the reset.
        push_wr(5'd14, 32'hFFFFFFFE);
        issue(2'd1, 1, 5'd12, 5'd13, 5'd14, 1'b1, 1'b1, c);
        drain();

        repeat (5) @(negedge g_clk);
        check("final_wr_queue", exp_wr.size(), 0);
        check("final_done_queue", exp_dn.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
